alu_muldiv_unit: RTL and testbench
==================================

Name: alu_muldiv_unit

Overview:
- Parametrised successor to the single-cycle ALU top level of the datapath.
- Executes the combinational ALU and shift ops in the same cycle they are presented.
- Adds a shared iterative multiply/divide engine (signed and unsigned) feeding HI/LO registers, plus mthi/mtlo writes.
- Sits in the EX stage; drives the stall output to the hazard unit while the engine is busy.

Parameters:
WIDTH, 32, datapath width (even, >=8); HI/LO are each WIDTH bits
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset (asserted when 0)
signal  input  4  operation select
dataA  input  WIDTH  operand A (rs)
dataB  input  WIDTH  operand B (rt / shift amount in dataB[log2 WIDTH-1:0])
dataOut  output  WIDTH  result
zero  output  1  dataOut == 0 for sub (branch compare)
bgtz  output  1  dataA signed > 0
busy  output  1  mul/div engine running
done  output  1  one-cycle pulse when HI/LO updated by engine
stall  output  1  current op must wait for engine

Behaviour:
- Opcodes: 0 and, 1 or, 2 add, 3 sll, 4 srl, 5 mfhi, 6 sub, 7 slt, 8 mflo, 9 mult, 10 multu, 11 div, 12 divu, 13 mthi, 14 mtlo, 15 sra. Codes 0-8 keep their existing encodings.
- Combinational ops (0-4, 6, 7, 15): dataOut valid in the same cycle. add/sub wrap modulo 2^WIDTH. slt is signed and returns 1 or 0 zero-extended. Shift amount is dataB[log2(WIDTH)-1:0]. sra sign-extends.
- mfhi/mflo: dataOut = HI/LO register. Ops 9-14 drive dataOut = 0.
- Reset (reset=0, async): FSM to IDLE; HI, LO, counter, partial regs = 0; busy=0, done=0.
- FSM states IDLE, MUL, DIV, FIX.
- IDLE with op 9/10 -> MUL. IDLE with op 11/12 -> DIV. In both cases latch magnitudes (signed ops) or raw operands, latch result-sign flags, counter = WIDTH.
- MUL/DIV: one shift-add or restoring-subtract step per cycle; counter decrements; when counter reaches 1 -> FIX.
- FIX: apply two's-complement sign correction. Product: HI:LO. Quotient -> LO, remainder -> HI; remainder takes the sign of the dividend. Write HI/LO, pulse done, return to IDLE.
- Latency: op sampled at edge 0; busy=1 for cycles 1..WIDTH+1; HI/LO and done visible in cycle WIDTH+1; busy=0 from cycle WIDTH+2. Latency is uniform for every operand value.
- Divide by zero: LO = all ones, HI = dividend. Latency is unchanged.
- Signed overflow (MIN / -1): LO = MIN, HI = 0.
- mthi/mtlo in IDLE: HI/LO <= dataA at the edge.
- stall = busy AND signal in {5, 8, 9-14}. A stalled op has no effect: a new mul/div is not started, mthi/mtlo does not write, and mfhi/mflo output is don't-care. The pipeline holds the op until stall drops.
- Combinational ops are never stalled and run in parallel with the engine.
- Reset mid-operation aborts the operation; HI/LO = 0 and done is not pulsed.
- zero and bgtz are combinational from the current operands and result.

Decomposition:
- Shared package alu_pkg: 4-bit opcode localparams (ALU_and ... ALU_sra), FSM state enum, helper function is_hilo_op.
- One natural sub-module: muldiv_engine (FSM, counter, partial-product/remainder registers, sign fixup, HI/LO). The top keeps the combinational ALU/shift mux and the stall logic.

Test Plan:
- Reset held low with ops applied -> HI=LO=0, busy=0, done=0; mfhi after release returns 0.
- WIDTH=32, mult with A=0xFFFFFFFE (-2), B=3 -> done in cycle 33, busy cycles 1..33; mfhi=0xFFFFFFFF, mflo=0xFFFFFFFA. multu with same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- add 5+7 issued during a busy mult -> dataOut=12 the same cycle, stall=0. mflo issued while busy -> stall=1 until engine finishes, then returns the new LO.
- mthi A=0x12345678 in IDLE -> mfhi next cycle = 0x12345678. mtlo while busy -> stall=1 and LO unchanged. Reset pulsed at cycle 10 of a div -> busy=0, HI=LO=0, no done pulse.
- WIDTH=16 instance: sra 0x8000 by 15 -> 0xFFFF; slt -1 < 1 -> 1; sub 4-4 -> zero=1; mult latency 17 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, engine state encoding and decode helpers for the EX-stage ALU.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_and   = 4'd0;
  localparam logic [OP_W-1:0] ALU_or    = 4'd1;
  localparam logic [OP_W-1:0] ALU_add   = 4'd2;
  localparam logic [OP_W-1:0] ALU_sll   = 4'd3;
  localparam logic [OP_W-1:0] ALU_srl   = 4'd4;
  localparam logic [OP_W-1:0] ALU_mfhi  = 4'd5;
  localparam logic [OP_W-1:0] ALU_sub   = 4'd6;
  localparam logic [OP_W-1:0] ALU_slt   = 4'd7;
  localparam logic [OP_W-1:0] ALU_mflo  = 4'd8;
  localparam logic [OP_W-1:0] ALU_mult  = 4'd9;
  localparam logic [OP_W-1:0] ALU_multu = 4'd10;
  localparam logic [OP_W-1:0] ALU_div   = 4'd11;
  localparam logic [OP_W-1:0] ALU_divu  = 4'd12;
  localparam logic [OP_W-1:0] ALU_mthi  = 4'd13;
  localparam logic [OP_W-1:0] ALU_mtlo  = 4'd14;
  localparam logic [OP_W-1:0] ALU_sra   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // Ops that touch HI/LO or the engine and therefore must wait while it is busy
  function automatic logic is_hilo_op(input logic [OP_W-1:0] op);
    return (op == ALU_mfhi) || (op == ALU_mflo) ||
           ((op >= ALU_mult) && (op <= ALU_mtlo));
  endfunction

endpackage

// File: rtl/muldiv_engine.sv
// Iterative signed/unsigned multiply/divide engine owning the HI/LO registers.
// One shift-add (mul) or restoring-subtract (div) step per cycle; the final step
// also applies sign correction and writes HI/LO so results appear in cycle WIDTH+1.
module muldiv_engine
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned DW    = 2 * WIDTH;

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_acc;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] r_opnd;    // mul: multiplicand; div: divisor
  logic             r_neg_lo;  // negate product / quotient at the end
  logic             r_neg_hi;  // negate remainder at the end
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_is_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_mul_sum;
  logic [DW-1:0]    w_mul_next;
  logic [DW-1:0]    w_prod_fix;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic [DW-1:0]    w_div_next;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand decode: magnitudes for signed ops, raw values otherwise
  assign w_is_signed = (i_op == ALU_mult) || (i_op == ALU_div);
  assign w_a_neg     = w_is_signed & i_a[WIDTH-1];
  assign w_b_neg     = w_is_signed & i_b[WIDTH-1];
  assign w_b_zero    = (i_b == '0);
  assign w_a_mag     = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
  assign w_b_mag     = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;

  // Shift-add multiply step
  assign w_mul_sum  = {1'b0, r_acc[DW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod_fix = r_neg_lo ? (~w_mul_next + DW'(1)) : w_mul_next;

  // Restoring divide step; a zero divisor naturally yields all-ones quotient and remainder = dividend
  assign w_rem_sh   = r_acc[DW-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
  assign w_quo_fix  = r_neg_lo ? (~w_div_next[WIDTH-1:0] + WIDTH'(1)) : w_div_next[WIDTH-1:0];
  assign w_rem_fix  = r_neg_hi ? (~w_div_next[DW-1:WIDTH] + WIDTH'(1)) : w_div_next[DW-1:WIDTH];

  // Engine FSM, iteration datapath and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if ((i_op == ALU_mult) || (i_op == ALU_multu)) begin
            r_state  <= ST_MUL;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH);
            r_acc    <= {{WIDTH{1'b0}}, w_b_mag};
            r_opnd   <= w_a_mag;
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= 1'b0;
          end else if ((i_op == ALU_div) || (i_op == ALU_divu)) begin
            r_state  <= ST_DIV;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_W'(WIDTH);
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_opnd   <= w_b_mag;
            r_neg_lo <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
            r_neg_hi <= w_a_neg;
          end else if (i_op == ALU_mthi) begin
            r_hi <= i_a;
          end else if (i_op == ALU_mtlo) begin
            r_lo <= i_a;
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= w_prod_fix[DW-1:WIDTH];
            r_lo    <= w_prod_fix[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= ST_FIX;
          end
        end
        ST_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= w_rem_fix;
            r_lo    <= w_quo_fix;
            r_done  <= 1'b1;
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus a shared iterative
// mul/div engine feeding HI/LO, with a stall request to the hazard unit.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             bgtz,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_busy;
  logic             w_done;
  logic [SH_W-1:0]  w_shamt;
  logic [WIDTH-1:0] w_result;

  // The engine only accepts ops in IDLE, so stalled HI/LO ops are ignored there
  muldiv_engine #(.WIDTH(WIDTH)) u_engine (
    .clk    (clk),
    .rst_n  (reset),
    .i_op   (signal),
    .i_a    (dataA),
    .i_b    (dataB),
    .o_hi   (w_hi),
    .o_lo   (w_lo),
    .o_busy (w_busy),
    .o_done (w_done)
  );

  assign w_shamt = dataB[SH_W-1:0];

  // Single-cycle result mux; engine-launch and HI/LO-write ops return zero
  always_comb begin
    w_result = '0;
    case (signal)
      ALU_and:  w_result = dataA & dataB;
      ALU_or:   w_result = dataA | dataB;
      ALU_add:  w_result = dataA + dataB;
      ALU_sll:  w_result = dataA << w_shamt;
      ALU_srl:  w_result = dataA >> w_shamt;
      ALU_mfhi: w_result = w_hi;
      ALU_sub:  w_result = dataA - dataB;
      ALU_slt:  w_result = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      ALU_mflo: w_result = w_lo;
      ALU_sra:  w_result = WIDTH'($signed(dataA) >>> w_shamt);
      default:  w_result = '0;
    endcase
  end

  assign dataOut = w_result;
  assign zero    = (w_result == '0);
  assign bgtz    = ~dataA[WIDTH-1] & (dataA != '0);
  assign busy    = w_busy;
  assign done    = w_done;
  assign stall   = w_busy & is_hilo_op(signal);

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Self-checking bench for alu_muldiv_unit at WIDTH=32 and WIDTH=16.
`timescale 1ns/1ps
module tb_alu_muldiv_unit;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int W2 = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  sig32, sig16;
  logic [31:0] a32, b32, out32;
  logic [15:0] a16, b16, out16;
  logic zero32, bgtz32, busy32, done32, stall32;
  logic zero16, bgtz16, busy16, done16, stall16;

  alu_muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .signal(sig32), .dataA(a32), .dataB(b32),
    .dataOut(out32), .zero(zero32), .bgtz(bgtz32), .busy(busy32),
    .done(done32), .stall(stall32)
  );

  alu_muldiv_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .reset(rst_n), .signal(sig16), .dataA(a16), .dataB(b16),
    .dataOut(out16), .zero(zero16), .bgtz(bgtz16), .busy(busy16),
    .done(done16), .stall(stall16)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct { logic [31:0] hi; logic [31:0] lo; } hl_t;
  hl_t sb_q[$];

  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] y; } cv_t;

  // Reference HI/LO for mul/div at width w, using wide integer arithmetic
  function automatic logic [63:0] model_hl(input int w, input logic [3:0] op,
                                           input logic [31:0] a, input logic [31:0] b);
    longint unsigned mask, ua, ub, p, hi, lo;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    ua = 64'(a) & mask;
    ub = 64'(b) & mask;
    sa = ua[w-1] ? (longint'(ua) - longint'(64'd1 << w)) : longint'(ua);
    sb = ub[w-1] ? (longint'(ub) - longint'(64'd1 << w)) : longint'(ub);
    hi = 64'd0;
    lo = 64'd0;
    case (op)
      ALU_mult:  begin p = 64'(sa * sb); hi = (p >> w) & mask; lo = p & mask; end
      ALU_multu: begin p = ua * ub;      hi = (p >> w) & mask; lo = p & mask; end
      ALU_div: begin
        if (ub == 64'd0) begin lo = mask; hi = ua; end
        else begin q = sa / sb; r = sa % sb; lo = 64'(q) & mask; hi = 64'(r) & mask; end
      end
      ALU_divu: begin
        if (ub == 64'd0) begin lo = mask; hi = ua; end
        else begin lo = ua / ub; hi = ua % ub; end
      end
      default: ;
    endcase
    return {32'(hi), 32'(lo)};
  endfunction

  task automatic read_hilo32(output logic [31:0] hi, output logic [31:0] lo);
    @(negedge clk); sig32 = ALU_mfhi; #1; hi = out32;
    @(negedge clk); sig32 = ALU_mflo; #1; lo = out32;
    @(negedge clk); sig32 = ALU_and;
  endtask

  task automatic read_hilo16(output logic [15:0] hi, output logic [15:0] lo);
    @(negedge clk); sig16 = ALU_mfhi; #1; hi = out16;
    @(negedge clk); sig16 = ALU_mflo; #1; lo = out16;
    @(negedge clk); sig16 = ALU_and;
  endtask

  task automatic test_reset();
    logic [31:0] hi, lo;
    logic [15:0] hi16, lo16;
    rst_n = 1'b0;
    sig32 = ALU_mult; a32 = 32'hFFFF_FFFE; b32 = 32'd3;
    sig16 = ALU_mthi; a16 = 16'h1234;      b16 = 16'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) sig32 = ALU_mthi;
      #1;
      vec_cnt++;
      if (busy32 !== 1'b0 || done32 !== 1'b0 || busy16 !== 1'b0)
        begin err_cnt++; $display("FAIL reset_hold: busy32=%b done32=%b busy16=%b want 0", busy32, done32, busy16); end
    end
    @(negedge clk); sig32 = ALU_and; sig16 = ALU_and; rst_n = 1'b1;
    read_hilo32(hi, lo);
    vec_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0)
      begin err_cnt++; $display("FAIL reset_hilo32: hi=%h lo=%h want 0", hi, lo); end
    read_hilo16(hi16, lo16);
    vec_cnt++;
    if (hi16 !== 16'd0 || lo16 !== 16'd0)
      begin err_cnt++; $display("FAIL reset_hilo16: hi=%h lo=%h want 0", hi16, lo16); end
  endtask

  task automatic test_comb32();
    cv_t tbl[$];
    tbl.push_back('{ALU_and, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234});
    tbl.push_back('{ALU_or,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F});
    tbl.push_back('{ALU_add, 32'hFFFF_FFFF, 32'd2,         32'd1});
    tbl.push_back('{ALU_add, 32'd5,         32'd7,         32'd12});
    tbl.push_back('{ALU_sll, 32'd1,         32'hFFFF_FFFF, 32'h8000_0000});
    tbl.push_back('{ALU_srl, 32'h8000_0000, 32'd4,         32'h0800_0000});
    tbl.push_back('{ALU_sra, 32'h8000_0000, 32'd4,         32'hF800_0000});
    tbl.push_back('{ALU_sra, 32'h7000_0000, 32'd33,        32'h3800_0000});
    tbl.push_back('{ALU_sub, 32'd4,         32'd4,         32'd0});
    tbl.push_back('{ALU_sub, 32'd3,         32'd5,         32'hFFFF_FFFE});
    tbl.push_back('{ALU_slt, 32'hFFFF_FFFF, 32'd1,         32'd1});
    tbl.push_back('{ALU_slt, 32'd1,         32'hFFFF_FFFF, 32'd0});
    tbl.push_back('{ALU_mult, 32'd9,        32'd9,         32'd0});
    foreach (tbl[i]) begin
      @(negedge clk); sig32 = tbl[i].op; a32 = tbl[i].a; b32 = tbl[i].b; #1;
      vec_cnt++;
      if (out32 !== tbl[i].y || zero32 !== (tbl[i].y == 32'd0))
        begin err_cnt++; $display("FAIL comb32[%0d] op=%0d: out=%h zero=%b want %h", i, tbl[i].op, out32, zero32, tbl[i].y); end
      if (tbl[i].op == ALU_mult) begin
        @(negedge clk); sig32 = ALU_and;
        for (int c = 2; c <= W + 2; c++) @(negedge clk);
        sb_q.push_back('{32'd0, 32'd81});
        read_hilo32(sb_q[$].hi, sb_q[$].lo);
        vec_cnt++;
        if (sb_q[$].lo !== 32'd81)
          begin err_cnt++; $display("FAIL comb32_mult_side: lo=%h want 00000051", sb_q[$].lo); end
        void'(sb_q.pop_back());
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); sig32 = ALU_and;
      a32 = (i == 0) ? 32'd1 : (i == 1) ? 32'd0 : 32'h8000_0000; #1;
      vec_cnt++;
      if (bgtz32 !== (i == 0))
        begin err_cnt++; $display("FAIL bgtz32 a=%h: got %b want %b", a32, bgtz32, (i == 0)); end
    end
  endtask

  // Issue one mul/div on the 32-bit DUT, check busy/done every cycle, then HI/LO
  task automatic test_muldiv32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m;
    hl_t exp;
    logic [31:0] hi, lo;
    m = model_hl(W, op, a, b);
    sb_q.push_back('{m[63:32], m[31:0]});
    @(negedge clk); sig32 = op; a32 = a; b32 = b;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin sig32 = ALU_and; a32 = ~a; b32 = ~b; end
      #1;
      vec_cnt++;
      if (busy32 !== (c <= W + 1) || done32 !== (c == W + 1))
        begin err_cnt++; $display("FAIL muldiv32_timing op=%0d cyc=%0d: busy=%b done=%b", op, c, busy32, done32); end
    end
    read_hilo32(hi, lo);
    exp = sb_q.pop_front();
    vec_cnt++;
    if (hi !== exp.hi || lo !== exp.lo)
      begin err_cnt++; $display("FAIL muldiv32 op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h", op, a, b, hi, lo, exp.hi, exp.lo); end
  endtask

  task automatic test_muldiv16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [63:0] m;
    hl_t exp;
    logic [15:0] hi, lo;
    m = model_hl(W2, op, 32'(a), 32'(b));
    sb_q.push_back('{m[63:32], m[31:0]});
    @(negedge clk); sig16 = op; a16 = a; b16 = b;
    for (int c = 1; c <= W2 + 2; c++) begin
      @(negedge clk);
      if (c == 1) sig16 = ALU_and;
      #1;
      vec_cnt++;
      if (busy16 !== (c <= W2 + 1) || done16 !== (c == W2 + 1))
        begin err_cnt++; $display("FAIL muldiv16_timing op=%0d cyc=%0d: busy=%b done=%b", op, c, busy16, done16); end
    end
    read_hilo16(hi, lo);
    exp = sb_q.pop_front();
    vec_cnt++;
    if (32'(hi) !== exp.hi || 32'(lo) !== exp.lo)
      begin err_cnt++; $display("FAIL muldiv16 op=%0d a=%h b=%h: hi=%h lo=%h want hi=%h lo=%h", op, a, b, hi, lo, exp.hi, exp.lo); end
  endtask

  task automatic test_parallel();
    logic [63:0] m;
    hl_t exp;
    logic [31:0] lo_seen;
    m = model_hl(W, ALU_mult, 32'h0000_1234, 32'hFFFF_FF00);
    sb_q.push_back('{m[63:32], m[31:0]});
    lo_seen = 32'hx;
    @(negedge clk); sig32 = ALU_mult; a32 = 32'h0000_1234; b32 = 32'hFFFF_FF00;
    @(negedge clk); sig32 = ALU_add; a32 = 32'd5; b32 = 32'd7; #1;
    vec_cnt++;
    if (out32 !== 32'd12 || stall32 !== 1'b0 || busy32 !== 1'b1)
      begin err_cnt++; $display("FAIL parallel_add: out=%h stall=%b busy=%b want 0000000c 0 1", out32, stall32, busy32); end
    for (int c = 2; c <= W + 2; c++) begin
      @(negedge clk); sig32 = ALU_mflo; #1;
      vec_cnt++;
      if (stall32 !== (c <= W + 1))
        begin err_cnt++; $display("FAIL parallel_stall cyc=%0d: stall=%b want %b", c, stall32, (c <= W + 1)); end
      if (c == W + 2) lo_seen = out32;
    end
    @(negedge clk); sig32 = ALU_and;
    exp = sb_q.pop_front();
    vec_cnt++;
    if (lo_seen !== exp.lo)
      begin err_cnt++; $display("FAIL parallel_mflo: got %h want %h", lo_seen, exp.lo); end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] m;
    hl_t exp;
    logic [31:0] hi, lo;
    @(negedge clk); sig32 = ALU_mthi; a32 = 32'h1234_5678;
    @(negedge clk); sig32 = ALU_mfhi; a32 = 32'd0; #1;
    vec_cnt++;
    if (out32 !== 32'h1234_5678)
      begin err_cnt++; $display("FAIL mthi: mfhi=%h want 12345678", out32); end
    @(negedge clk); sig32 = ALU_mtlo; a32 = 32'h0BAD_F00D;
    @(negedge clk); sig32 = ALU_mflo; #1;
    vec_cnt++;
    if (out32 !== 32'h0BAD_F00D)
      begin err_cnt++; $display("FAIL mtlo: mflo=%h want 0badf00d", out32); end
    m = model_hl(W, ALU_multu, 32'hFFFF_FFFE, 32'd3);
    sb_q.push_back('{m[63:32], m[31:0]});
    @(negedge clk); sig32 = ALU_multu; a32 = 32'hFFFF_FFFE; b32 = 32'd3;
    for (int c = 1; c <= W + 1; c++) begin
      @(negedge clk); sig32 = (c % 2 == 1) ? ALU_mtlo : ALU_mthi; a32 = 32'hDEAD_BEEF; #1;
      vec_cnt++;
      if (stall32 !== 1'b1)
        begin err_cnt++; $display("FAIL mtx_stall cyc=%0d: stall=%b want 1", c, stall32); end
    end
    @(negedge clk); sig32 = ALU_and;
    read_hilo32(hi, lo);
    exp = sb_q.pop_front();
    vec_cnt++;
    if (hi !== exp.hi || lo !== exp.lo)
      begin err_cnt++; $display("FAIL mtx_blocked: hi=%h lo=%h want hi=%h lo=%h", hi, lo, exp.hi, exp.lo); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hi, lo;
    int done_seen;
    done_seen = 0;
    @(negedge clk); sig32 = ALU_div; a32 = 32'hFFFF_FFF9; b32 = 32'd2;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); sig32 = ALU_and;
    end
    rst_n = 1'b0; #1;
    vec_cnt++;
    if (busy32 !== 1'b0 || done32 !== 1'b0)
      begin err_cnt++; $display("FAIL reset_mid_abort: busy=%b done=%b want 0 0", busy32, done32); end
    #2 rst_n = 1'b1;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk); #1;
      if (done32 !== 1'b0 || busy32 !== 1'b0) done_seen++;
    end
    vec_cnt++;
    if (done_seen != 0)
      begin err_cnt++; $display("FAIL reset_mid_quiet: %0d cycles with busy/done set, want 0", done_seen); end
    read_hilo32(hi, lo);
    vec_cnt++;
    if (hi !== 32'd0 || lo !== 32'd0)
      begin err_cnt++; $display("FAIL reset_mid_hilo: hi=%h lo=%h want 0", hi, lo); end
  endtask

  task automatic test_w16();
    @(negedge clk); sig16 = ALU_sra; a16 = 16'h8000; b16 = 16'd15; #1;
    vec_cnt++;
    if (out16 !== 16'hFFFF)
      begin err_cnt++; $display("FAIL w16_sra: got %h want ffff", out16); end
    @(negedge clk); sig16 = ALU_slt; a16 = 16'hFFFF; b16 = 16'd1; #1;
    vec_cnt++;
    if (out16 !== 16'd1)
      begin err_cnt++; $display("FAIL w16_slt: got %h want 0001", out16); end
    @(negedge clk); sig16 = ALU_sub; a16 = 16'd4; b16 = 16'd4; #1;
    vec_cnt++;
    if (out16 !== 16'd0 || zero16 !== 1'b1)
      begin err_cnt++; $display("FAIL w16_sub_zero: out=%h zero=%b want 0000 1", out16, zero16); end
    test_muldiv16(ALU_mult, 16'hFFFE, 16'd3);
    test_muldiv16(ALU_div,  16'h8000, 16'hFFFF);
    test_muldiv16(ALU_divu, 16'd1234, 16'd0);
  endtask

  task automatic test_random32();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'(ALU_mult + 4'($urandom_range(0, 3)));
      case ($urandom_range(0, 5))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 100));
        default: b = $urandom;
      endcase
      test_muldiv32(op, a, b);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sig32 = ALU_and; a32 = '0; b32 = '0;
    sig16 = ALU_and; a16 = '0; b16 = '0;
    test_reset();
    test_comb32();
    test_muldiv32(ALU_mult,  32'hFFFF_FFFE, 32'd3);
    test_muldiv32(ALU_multu, 32'hFFFF_FFFE, 32'd3);
    test_muldiv32(ALU_div,   32'hFFFF_FFF9, 32'd2);
    test_muldiv32(ALU_divu,  32'd7,         32'd0);
    test_muldiv32(ALU_div,   32'h8000_0000, 32'hFFFF_FFFF);
    test_muldiv32(ALU_div,   32'hFFFF_FFF9, 32'd0);
    test_muldiv32(ALU_divu,  32'hFFFF_FFF9, 32'd2);
    test_parallel();
    test_mthi_mtlo();
    test_reset_mid();
    test_w16();
    test_random32();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
